// File: rtl/demux4_dispatch_pkg.sv
// Shared definitions for the four-channel dispatcher: channel count, select
// width, the channel index type and the width of the optional statistics
// counters (enabled with DEMUX4_DISPATCH_CNT_EN).
package demux4_dispatch_pkg;

  localparam int CH_N  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef logic [SEL_W-1:0] chan_idx_t;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux4_dispatch_chan_fifo.sv
// One dispatcher channel: a small FIFO with registered storage.
// The head word is read combinationally and forced to zero when empty.
// Pops on an empty FIFO are ignored.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module demux_chan_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          valid
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          is_full;
  logic          pop_en;
  logic          push_en;

  assign valid   = (cnt_q != '0);
  assign is_full = (cnt_q == CW'(DEPTH));
  assign pop_en  = pop && valid;
  assign push_en = push && (!is_full || pop_en);
  assign count   = cnt_q;

  // Pointers and occupancy. DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array. It has no reset because the occupancy count already hides stale entries.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  assign head_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/demux4_dispatch.sv
// Registered 1-to-4 dispatcher. Each input word is routed by in_sel into one
// of four per-channel FIFOs, so a stalled consumer only blocks its own channel.
// Optional feature macro: DEMUX4_DISPATCH_CNT_EN adds per-channel delivery
// counters (cnt_0..cnt_3) and a stall counter (drop_cnt).
module demux4_dispatch
  import demux4_dispatch_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic [CH_N-1:0]  out_valid,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  input  logic [CH_N-1:0]  out_ready,
  output logic [CH_N-1:0]  full
`ifdef DEMUX4_DISPATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1,
  output logic [CNT_W-1:0] cnt_2,
  output logic [CNT_W-1:0] cnt_3
`endif
);

  logic [CH_N-1:0] push;
  logic [W-1:0]    head  [CH_N];
  logic [CW-1:0]   count [CH_N];

  // A full channel can still take a word when its consumer pops in the same cycle.
  assign in_ready = !full[in_sel] || out_ready[in_sel];

  for (genvar k = 0; k < CH_N; k++) begin : g_chan
    assign push[k] = in_valid && in_ready && (in_sel == chan_idx_t'(k));
    assign full[k] = (count[k] == CW'(DEPTH));

    demux_chan_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[k]),
      .pop       (out_ready[k]),
      .push_data (in_data),
      .head_data (head[k]),
      .count     (count[k]),
      .valid     (out_valid[k])
    );
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

`ifdef DEMUX4_DISPATCH_CNT_EN
  logic [CNT_W-1:0] dlv [CH_N];

  // Saturating delivery counters per channel, plus a counter of cycles where a word was offered but not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      for (int k = 0; k < CH_N; k++) dlv[k] <= '0;
    end else begin
      if (in_valid && !in_ready) drop_cnt <= sat_inc(drop_cnt);
      for (int k = 0; k < CH_N; k++) begin
        if (out_valid[k] && out_ready[k]) dlv[k] <= sat_inc(dlv[k]);
      end
    end
  end

  assign cnt_0 = dlv[0];
  assign cnt_1 = dlv[1];
  assign cnt_2 = dlv[2];
  assign cnt_3 = dlv[3];
`endif

endmodule

// File: tb/tb_demux4_dispatch.sv
// Directed testbench for demux4_dispatch with hand-computed expected values.
// The counter checks are compiled in only when DEMUX4_DISPATCH_CNT_EN is defined.
module tb_demux4_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_ready;
  logic [3:0] full;
`ifdef DEMUX4_DISPATCH_CNT_EN
  logic [15:0] drop_cnt, cnt_0, cnt_1, cnt_2, cnt_3;
`endif

  int errors = 0;
  int checks = 0;

  demux4_dispatch #(.W(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_ready (out_ready),
    .full      (full)
`ifdef DEMUX4_DISPATCH_CNT_EN
    ,
    .drop_cnt  (drop_cnt),
    .cnt_0     (cnt_0),
    .cnt_1     (cnt_1),
    .cnt_2     (cnt_2),
    .cnt_3     (cnt_3)
`endif
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all inputs, then let the combinational in_ready path settle.
  task automatic applyStimulus(input logic v, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Advance one clock edge and sample shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);

    // Reset state.
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_out_data0", 32'(out_data0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Routing: one word into each channel, with no consumer ready.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), 8'hA0 + 8'(k), 4'b0000);
      checkOutput($sformatf("route_ready%0d", k), 32'(in_ready), 32'h1);
      if (k == 0) checkOutput("route_no_bypass", 32'(out_valid), 32'h0);
      tick();
      if (k == 0) checkOutput("route_latency", 32'(out_valid), 32'h1);
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("route_valid", 32'(out_valid), 32'hF);
    checkOutput("route_d0", 32'(out_data0), 32'hA0);
    checkOutput("route_d1", 32'(out_data1), 32'hA1);
    checkOutput("route_d2", 32'(out_data2), 32'hA2);
    checkOutput("route_d3", 32'(out_data3), 32'hA3);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    checkOutput("route_drained", 32'(out_valid), 32'h0);

    // Backpressure on channel 2: a third word stalls until the consumer pops.
    applyStimulus(1'b1, 2'd2, 8'h11, 4'b0000);
    tick();
    checkOutput("bp_full_after1", 32'(full), 32'h0);
    applyStimulus(1'b1, 2'd2, 8'h22, 4'b0000);
    tick();
    checkOutput("bp_full_after2", 32'(full), 32'h4);
    applyStimulus(1'b1, 2'd2, 8'h33, 4'b0000);
    checkOutput("bp_stall_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bp_head_held", 32'(out_data2), 32'h11);
    applyStimulus(1'b1, 2'd2, 8'h33, 4'b0100);
    checkOutput("bp_passthru_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_head_22", 32'(out_data2), 32'h22);
    checkOutput("bp_still_full", 32'(full), 32'h4);

    // Isolation: channel 2 is full and stalled, but channel 0 still accepts.
    applyStimulus(1'b1, 2'd0, 8'h55, 4'b0000);
    checkOutput("iso_ready", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("iso_valid", 32'(out_valid), 32'h5);
    checkOutput("iso_d0", 32'(out_data0), 32'h55);
    checkOutput("iso_d2", 32'(out_data2), 32'h22);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0101);
    tick();
    checkOutput("bp_head_33", 32'(out_data2), 32'h33);
    checkOutput("bp_valid_33", 32'(out_valid), 32'h4);
    tick();
    checkOutput("bp_drained", 32'(out_valid), 32'h0);

    // Reset mid-run while two words sit in channel 1.
    applyStimulus(1'b1, 2'd1, 8'hC0, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 8'hC1, 4'b0000);
    tick();
    checkOutput("mid_full1", 32'(full), 32'h2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_full", 32'(full), 32'h0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'h1);
    checkOutput("mid_rst_d1", 32'(out_data1), 32'h0);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("mid_post_valid", 32'(out_valid), 32'h0);

    // Channel 3 is kept full while it is pushed and popped in the same cycle over 10 cycles.
    applyStimulus(1'b1, 2'd3, 8'h30, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd3, 8'h31, 4'b0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'd3, 8'h32 + 8'(i), 4'b1000);
      checkOutput($sformatf("pp_ready%0d", i), 32'(in_ready), 32'h1);
      checkOutput($sformatf("pp_head%0d", i), 32'(out_data3), 32'h30 + 32'(i));
      tick();
      checkOutput($sformatf("pp_full%0d", i), 32'(full), 32'h8);
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1000);
    checkOutput("pp_tail0", 32'(out_data3), 32'h3A);
    tick();
    checkOutput("pp_tail1", 32'(out_data3), 32'h3B);
    tick();
    checkOutput("pp_drained", 32'(out_valid), 32'h0);

    // Pops on empty channels are ignored, and changing in_sel while idle has no effect.
    applyStimulus(1'b0, 2'd2, 8'hEE, 4'b1111);
    tick();
    applyStimulus(1'b0, 2'd1, 8'hDD, 4'b1111);
    tick();
    checkOutput("empty_pop_valid", 32'(out_valid), 32'h0);

    // All four channels pop while channel 1 is pushed in the same cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), 8'h60 + 8'(k), 4'b0000);
      tick();
    end
    applyStimulus(1'b1, 2'd1, 8'h77, 4'b1111);
    checkOutput("all_pop_ready", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("all_pop_valid", 32'(out_valid), 32'h2);
    checkOutput("all_pop_d1", 32'(out_data1), 32'h77);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();

`ifdef DEMUX4_DISPATCH_CNT_EN
    // Counters: 3 stall cycles and 5 deliveries on channel 1, counted from a fresh reset.
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 2'd1, 8'h81, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h82, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h83, 4'b0000);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(1'b0, 2'd1, 8'h00, 4'b0010);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd1, 8'h90 + 8'(i), 4'b0000);
      tick();
      applyStimulus(1'b0, 2'd1, 8'h00, 4'b0010);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("cnt_1", 32'(cnt_1), 32'd5);
    checkOutput("cnt_drop", 32'(drop_cnt), 32'd3);
    checkOutput("cnt_0", 32'(cnt_0), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("cnt_1_rst", 32'(cnt_1), 32'd0);
    checkOutput("cnt_drop_rst", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
- Registered 1-to-4 demultiplexer: the distribution side of the 4-to-1 select path.
- Accepts one data word per cycle on a single valid/ready input and steers it to one of four output channels chosen by a 2-bit select.
- Each channel has its own small FIFO, so a stalled destination never blocks traffic to the other three unless its own FIFO is full.
- Sits between a shared producer (e.g. a writeback or result bus) and four independent consumers.

Parameters:
- W, 8, data word width.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_data  in  W  input word.
- in_sel  in  2  destination channel, 0..3; bit 1 is the high select, bit 0 the low select.
- in_ready  out  1  dispatcher can accept the word addressed by in_sel this cycle.
- out_valid  out  4  bit k: channel k head entry valid.
- out_data0..out_data3  out  W each  channel head data.
- out_ready  in  4  bit k: consumer k takes its head this cycle.
- full  out  4  bit k: channel k FIFO holds DEPTH entries.

Behaviour:
- Reset:
  - Asynchronous, active-high; all FIFO pointers and counts go to 0 immediately.
  - out_valid=0, full=0, out_data*=0, in_ready=1 while rst is high.
  - Reset mid-transfer discards all buffered words; no partial state survives.
- Handshake:
  - Input transfer when in_valid && in_ready at a clock edge.
  - Output transfer on channel k when out_valid[k] && out_ready[k].
  - in_valid and in_sel must stay stable while in_valid=1 and in_ready=0.
- in_ready:
  - Combinational: in_ready = !full[in_sel] || out_ready[in_sel].
  - A full channel being popped in the same cycle accepts a write (pass-through slot).
- Select decode:
  - one-hot push[k] = in_valid && in_ready && (in_sel==k).
  - Exactly one channel can be pushed per cycle.
- Per-channel FIFO:
  - Write pointer, read pointer, count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - push only: count+1. pop only: count-1. push and pop together: count unchanged, both pointers advance.
  - out_valid[k] = (count!=0). full[k] = (count==DEPTH).
  - out_data_k = mem[rd_ptr], read combinationally; 0 when empty.
- Latency: a word accepted at edge N appears on out_data_k with out_valid[k]=1 after edge N (one cycle). There is no bypass when empty.
- Ordering: FIFO order within a channel. There is no ordering guarantee across channels.
- Boundary cases:
  - Pop on an empty channel is ignored; out_ready is a don't-care when out_valid=0.
  - in_sel changing while in_valid=0 has no effect.
  - All four channels popping while one channel is pushed is legal and handled in one cycle.

Optional Feature:
- Macro: DEMUX4_DISPATCH_CNT_EN.
- When defined:
  - Adds output port drop_cnt (16 bits) and four 16-bit per-channel delivered counters, exposed as output cnt_k for k=0..3.
  - cnt_k increments on each output transfer of channel k and saturates at 16'hFFFF.
  - drop_cnt increments each cycle in_valid=1 and in_ready=0 (stall cycles) and saturates.
  - All counters reset to 0.
- When undefined: no extra ports or logic, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - CH_N=4 and SEL_W=2.
  - The typedef for the channel index.
  - A CNT_W=16 constant for the optional counters.
- Sub-module demux_chan_fifo: one-channel FIFO with push/pop/data/count/full/valid, instantiated four times.
- The top level contains only the select decode, the in_ready mux and the optional counters.

Test Plan:
- Reset then idle: rst=1 mid-run with 2 words buffered in ch1 -> immediately out_valid=4'b0000, full=0, in_ready=1.
- Routing: push 8'hA0,8'hA1,8'hA2,8'hA3 with sel 0,1,2,3 while out_ready=0 -> one cycle later out_valid=4'b1111 and out_data0..3 = A0..A3.
- Full/backpressure: push 8'h11,8'h22,8'h33 to sel=2 with out_ready[2]=0 -> full[2]=1 after two pushes; in_ready=0 for the third; 8'h33 is accepted on the cycle out_ready[2] rises; pop order 11,22,33.
- Isolation: ch2 full and stalled, push 8'h55 to sel=0 -> in_ready=1 and ch0 delivers 8'h55 next cycle.
- Simultaneous push/pop on full ch3: count stays 2, pointers wrap correctly over 10 consecutive cycles; output sequence matches the input sequence exactly.
- With DEMUX4_DISPATCH_CNT_EN defined: 5 deliveries on ch1 and 3 stall cycles -> cnt_1=5, drop_cnt=3; after rst both read 0.
